// File: rtl/fp_pkg.sv
// Shared FP datapath constants, flag layout and the round/pack bundle.
// Imported by the rounding, packing and incrementer blocks.
package fp_pkg;

    localparam int PAT_W   = 50;
    localparam int LOC_W   = 6;
    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int EIN_W   = 10;
    localparam int EI1_W   = EIN_W + 1;

    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;

    // Bit of the normalized pattern just below the kept fraction.
    localparam int G_BIT   = PAT_W - 2 - MAN_W;
    localparam int JUST    = PAT_W - 2;

    typedef logic signed [EI1_W-1:0] exp_t;

    typedef struct packed {
        logic             sign;
        logic             zero;
        exp_t             e;
        logic [MAN_W-1:0] frac;
        logic             g;
        logic             s;
    } s1_t;

    function automatic logic [31:0] fp_pack(
        input logic             sign,
        input logic [EXP_W-1:0] e,
        input logic [MAN_W-1:0] f
    );
        return {sign, e, f};
    endfunction

    function automatic logic [31:0] fp_inf(input logic sign);
        return sign ? NEG_INF : POS_INF;
    endfunction

    function automatic logic [31:0] fp_zero(input logic sign);
        return sign ? NEG_ZERO : POS_ZERO;
    endfunction

endpackage

// File: rtl/fp32_round_pack_if.sv
// Input/output handshake bundle of the binary32 round-and-pack stage.
// The datapath drives the slave side; the producer/consumer the master side.
interface fp32_round_pack_if;
    import fp_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic             i_sign;
    logic [EIN_W-1:0] i_exp;
    logic [LOC_W-1:0] i_loc;
    logic [PAT_W-1:0] i_pat;
    logic             i_zero;

    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_data;
    logic [2:0]       o_flags;

    modport master (
        output i_valid, i_sign, i_exp, i_loc,
        output i_pat, i_zero, i_ready,
        input  o_ready, o_valid, o_data, o_flags
    );

    modport slave (
        input  i_valid, i_sign, i_exp, i_loc,
        input  i_pat, i_zero, i_ready,
        output o_ready, o_valid, o_data, o_flags
    );

endinterface

// File: rtl/fp_rne_incrementer.sv
// Round-to-nearest-even increment of a binary32 fraction from guard/sticky.
// Shared by the pack stage and the adder/multiplier rounding paths.
module fp_rne_incrementer
    import fp_pkg::*;
(
    input  logic [MAN_W-1:0] frac,
    input  logic             g,
    input  logic             s,
    output logic [MAN_W-1:0] frac_rnd,
    output logic             carry,
    output logic             inexact
);

    logic           rnd_up;
    logic [MAN_W:0] m;

    // Ties go up only when the kept lsb is odd.
    assign rnd_up   = g & (s | frac[0]);
    assign m        = {1'b0, frac} + {{MAN_W{1'b0}}, rnd_up};
    assign carry    = m[MAN_W];
    assign frac_rnd = m[MAN_W-1:0];
    assign inexact  = g | s;

endmodule

// File: rtl/fp32_round_pack.sv
// Two-stage round-to-nearest-even and binary32 pack after normalization.
// Stage 1 extracts fraction/guard/sticky; stage 2 rounds and packs.
module fp32_round_pack
    import fp_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    fp32_round_pack_if.slave   io
);

    localparam exp_t E_JUST = exp_t'(JUST);
    localparam exp_t E_TOP  = exp_t'(EXP_MAX);
    localparam exp_t E_BOT  = exp_t'(0);
    localparam exp_t E_ONE  = exp_t'(1);

    logic             s1_valid;
    logic             s2_valid;
    logic             s2_adv;
    logic             in_fire;

    s1_t              s1_d;
    s1_t              s1_q;

    exp_t             e_in;
    exp_t             loc_in;

    logic [MAN_W-1:0] frac_rnd;
    logic             carry;
    logic             inexact;
    exp_t             e_adj;
    logic             is_ovf;
    logic             is_unf;

    logic [31:0]      data_d;
    logic [31:0]      data_q;
    logic [2:0]       flags_d;
    logic [2:0]       flags_q;

    // The leading one is implicit; only its position feeds the exponent.
    logic             unused_msb;
    assign unused_msb = io.i_pat[PAT_W-1];

    assign s2_adv     = !s2_valid | io.i_ready;
    assign io.o_ready = !s1_valid | s2_adv;
    assign in_fire    = io.i_valid & io.o_ready;

    assign io.o_valid = s2_valid;
    assign io.o_data  = data_q;
    assign io.o_flags = flags_q;

    assign e_in   = {io.i_exp[EIN_W-1], io.i_exp};
    assign loc_in = {{(EI1_W-LOC_W){1'b0}}, io.i_loc};

    always_comb begin
        s1_d      = '0;
        s1_d.sign = io.i_sign;
        s1_d.zero = io.i_zero;
        s1_d.e    = e_in + loc_in - E_JUST;
        s1_d.frac = io.i_pat[JUST:G_BIT+1];
        s1_d.g    = io.i_pat[G_BIT];
        s1_d.s    = |io.i_pat[G_BIT-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (in_fire) begin
                s1_q <= s1_d;
            end
            if (in_fire) begin
                s1_valid <= 1'b1;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end
        end
    end

    fp_rne_incrementer u_rne (
        .frac     (s1_q.frac),
        .g        (s1_q.g),
        .s        (s1_q.s),
        .frac_rnd (frac_rnd),
        .carry    (carry),
        .inexact  (inexact)
    );

    always_comb begin
        e_adj   = s1_q.e;
        data_d  = '0;
        flags_d = '0;
        // Mantissa carry bumps the exponent; the fraction is already zero.
        if (carry) begin
            e_adj = s1_q.e + E_ONE;
        end
        is_ovf = !s1_q.zero && (e_adj >= E_TOP);
        is_unf = !s1_q.zero && (e_adj <= E_BOT);
        unique case (1'b1)
            s1_q.zero: begin
                data_d = fp_zero(s1_q.sign);
            end
            is_ovf: begin
                data_d           = fp_inf(s1_q.sign);
                flags_d[FLG_OVF] = 1'b1;
                flags_d[FLG_INX] = 1'b1;
            end
            is_unf: begin
                data_d           = fp_zero(s1_q.sign);
                flags_d[FLG_UNF] = 1'b1;
                flags_d[FLG_INX] = 1'b1;
            end
            default: begin
                data_d = fp_pack(s1_q.sign,
                                 e_adj[EXP_W-1:0],
                                 frac_rnd);
                flags_d[FLG_INX] = inexact;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            s2_valid <= 1'b0;
            data_q   <= '0;
            flags_q  <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                data_q  <= data_d;
                flags_q <= flags_d;
            end
        end
    end

endmodule
